// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared state encoding and register-field constants for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // r0 is hardwired, so a load targeting it never produces a usable value to wait for
    function automatic logic load_use(input logic       memread,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
        return memread && (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and the stage-register controls returned to them.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       halt;

    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_clr;
    logic       idex_clr;
    logic       exmem_clr;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, ex_branch_taken,
               mem_req, mem_ready, halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_clr, idex_clr, exmem_clr
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, ex_branch_taken,
               mem_req, mem_ready, halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_clr, idex_clr, exmem_clr
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with async clear; sticks at all-ones instead of wrapping.
module pipe_hazard_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for PC and pipeline stage registers: load-use stalls, branch flushes,
// data-memory waits with timeout, and a terminal halt state.
//
// state   | meaning
// RUN     | normal issue; stalls/flushes resolved each cycle
// MEMWAIT | pipeline frozen waiting for data memory
// HALTED  | terminal; only Clr leaves
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              Clr,
    pipe_hazard_ctrl_if.slave pif,
    output logic [1:0]        state,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt, nxt_wait;
    logic [1:0]        nxt_state;
    logic              set_err;
    logic              stall_inc, flush_inc;
    logic              lu, issue;
    logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic              ifid_clr, idex_clr, exmem_clr;

    assign lu = load_use(pif.ex_memread, pif.ex_rd, pif.id_rs, pif.id_rt, pif.id_uses_rt);

    // A cycle "issues" when memory is not holding the pipe: RUN without a pending miss,
    // or the completing cycle of MEMWAIT. Both resolve halt/branch/lu identically.
    assign issue = ((state == ST_RUN) && !(pif.mem_req && !pif.mem_ready)) ||
                   ((state == ST_MEMWAIT) && pif.mem_ready);

    always_comb begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_en   = 1'b0;
        exmem_en  = 1'b0;
        memwb_en  = 1'b0;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        nxt_state = state;
        nxt_wait  = wait_cnt;
        set_err   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        case (state)
            ST_RUN: begin
                if (pif.mem_req && !pif.mem_ready) begin
                    nxt_state = ST_MEMWAIT;
                    nxt_wait  = WAIT_W'(1);
                end
            end
            ST_MEMWAIT: begin
                if (!pif.mem_ready) begin
                    if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                        set_err   = 1'b1;
                        nxt_state = ST_HALTED;
                        nxt_wait  = '0;
                    end else begin
                        nxt_wait = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            ST_HALTED: begin
            end
            default: begin
                set_err   = 1'b1;
                nxt_state = ST_HALTED;
            end
        endcase

        if (issue) begin
            nxt_wait  = '0;
            nxt_state = pif.halt ? ST_HALTED : ST_RUN;
            if (pif.halt || pif.ex_branch_taken || !lu) begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                if (!pif.halt && pif.ex_branch_taken) begin
                    ifid_clr  = 1'b1;
                    idex_clr  = 1'b1;
                    flush_inc = 1'b1;
                end
            end else begin
                idex_en   = 1'b1;
                idex_clr  = 1'b1;
                exmem_en  = 1'b1;
                memwb_en  = 1'b1;
                stall_inc = 1'b1;
            end
        end

        // Reset freezes every stage and flushes the front end regardless of state
        if (Clr) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
        end
    end

    assign pif.pc_en     = pc_en;
    assign pif.ifid_en   = ifid_en;
    assign pif.idex_en   = idex_en;
    assign pif.exmem_en  = exmem_en;
    assign pif.memwb_en  = memwb_en;
    assign pif.ifid_clr  = ifid_clr;
    assign pif.idex_clr  = idex_clr;
    assign pif.exmem_clr = exmem_clr;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= nxt_state;
            wait_cnt <= nxt_wait;
            mem_err  <= mem_err | set_err;
        end
    end

    pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Clr   (Clr),
        .inc   (stall_inc),
        .count (stall_count)
    );

    pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Clr   (Clr),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with CNT_W=2 and MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic [1:0] state;
    logic       mem_err;
    logic [1:0] stall_count;
    logic [1:0] flush_count;

    int n_checks = 0;
    int n_err    = 0;

    pipe_hazard_ctrl_if pif ();

    pipe_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut (
        .Clk         (Clk),
        .Clr         (Clr),
        .pif         (pif),
        .state       (state),
        .mem_err     (mem_err),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int en_vec();
        return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en};
    endfunction

    function automatic int clr_vec();
        return {pif.ifid_clr, pif.idex_clr, pif.exmem_clr};
    endfunction

    task automatic idle();
        pif.id_rs = 5'd1; pif.id_rt = 5'd2; pif.id_uses_rt = 1'b0;
        pif.ex_memread = 1'b0; pif.ex_rd = 5'd0; pif.ex_branch_taken = 1'b0;
        pif.mem_req = 1'b0; pif.mem_ready = 1'b0; pif.halt = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs);
        pif.ex_memread = 1'b1; pif.ex_rd = rd; pif.id_rs = rs;
    endtask

    // advance one clock; inputs change and outputs are sampled between edges
    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic pulse_clr();
        Clr = 1'b1;
        #1;
        chk("clr_state", state, 0);
        chk("clr_stall", stall_count, 0);
        chk("clr_flush", flush_count, 0);
        chk("clr_err", mem_err, 0);
        chk("clr_en", en_vec(), 5'b00000);
        chk("clr_clr", clr_vec(), 3'b111);
        #1;
        Clr = 1'b0;
    endtask

    initial begin
        idle();
        #1;
        chk("rst_en", en_vec(), 5'b00000);
        chk("rst_clr", clr_vec(), 3'b111);
        chk("rst_state", state, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_flush", flush_count, 0);
        cyc();
        Clr = 1'b0;

        // plain RUN
        #1;
        chk("run_en", en_vec(), 5'b11111);
        chk("run_clr", clr_vec(), 3'b000);

        // load-use on rs
        set_lu(5'd8, 5'd8);
        #1;
        chk("lu_en", en_vec(), 5'b00111);
        chk("lu_clr", clr_vec(), 3'b010);
        cyc();
        chk("lu_stall", stall_count, 1);
        chk("lu_state", state, 0);

        // load to r0 never stalls
        set_lu(5'd0, 5'd0);
        #1;
        chk("r0_en", en_vec(), 5'b11111);
        chk("r0_clr", clr_vec(), 3'b000);
        cyc();
        chk("r0_stall", stall_count, 1);

        // rt match only counts when rt is a source
        set_lu(5'd9, 5'd3);
        pif.id_rt = 5'd9;
        #1;
        chk("rt_unused_en", en_vec(), 5'b11111);
        pif.id_uses_rt = 1'b1;
        #1;
        chk("rt_used_en", en_vec(), 5'b00111);
        cyc();
        chk("rt_stall", stall_count, 2);
        idle();

        // branch overrides a simultaneous load-use
        set_lu(5'd8, 5'd8);
        pif.ex_branch_taken = 1'b1;
        #1;
        chk("br_en", en_vec(), 5'b11111);
        chk("br_clr", clr_vec(), 3'b110);
        cyc();
        chk("br_flush", flush_count, 1);
        chk("br_stall", stall_count, 2);
        idle();

        // memory wait: three low cycles then ready, with a branch on the ready cycle
        pif.mem_req = 1'b1;
        #1;
        chk("mw0_en", en_vec(), 5'b00000);
        chk("mw0_clr", clr_vec(), 3'b000);
        cyc();
        chk("mw0_state", state, 1);
        chk("mw1_en", en_vec(), 5'b00000);
        cyc();
        chk("mw1_state", state, 1);
        chk("mw2_en", en_vec(), 5'b00000);
        cyc();
        chk("mw2_state", state, 1);
        pif.mem_ready = 1'b1;
        pif.ex_branch_taken = 1'b1;
        #1;
        chk("mw_rdy_en", en_vec(), 5'b11111);
        chk("mw_rdy_clr", clr_vec(), 3'b110);
        cyc();
        chk("mw_done_state", state, 0);
        chk("mw_done_flush", flush_count, 2);
        chk("mw_done_err", mem_err, 0);
        idle();

        // halt retires then freezes everything
        pif.halt = 1'b1;
        #1;
        chk("halt_en", en_vec(), 5'b11111);
        chk("halt_clr", clr_vec(), 3'b000);
        cyc();
        chk("halted_state", state, 2);
        set_lu(5'd8, 5'd8);
        pif.ex_branch_taken = 1'b1;
        pif.mem_req = 1'b1;
        pif.mem_ready = 1'b1;
        #1;
        chk("halted_en", en_vec(), 5'b00000);
        chk("halted_clr", clr_vec(), 3'b000);
        cyc();
        chk("halted_hold", state, 2);
        chk("halted_stall", stall_count, 2);
        chk("halted_flush", flush_count, 2);
        idle();
        pulse_clr();
        cyc();

        // timeout after 4 stalled cycles
        pif.mem_req = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("to3_state", state, 1);
        chk("to3_err", mem_err, 0);
        cyc();
        chk("to4_state", state, 2);
        chk("to4_err", mem_err, 1);
        pif.mem_ready = 1'b1;
        #1;
        chk("to_after_en", en_vec(), 5'b00000);
        cyc();
        chk("to_err_hold", mem_err, 1);
        idle();
        pulse_clr();
        cyc();

        // reset in MEMWAIT clears the wait counter: a fresh miss needs 4 more cycles
        pif.mem_req = 1'b1;
        cyc();
        cyc();
        chk("mwr_state", state, 1);
        pulse_clr();
        cyc();
        cyc();
        cyc();
        chk("mwr3_state", state, 1);
        chk("mwr3_err", mem_err, 0);
        cyc();
        chk("mwr4_state", state, 2);
        idle();
        pulse_clr();
        cyc();

        // saturation at 2'b11
        set_lu(5'd5, 5'd5);
        for (int i = 0; i < 5; i++) cyc();
        chk("sat_stall", stall_count, 3);
        chk("sat_state", state, 0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Drives every per-stage En and flush (clear) request.
- Resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Provides a terminal halt/error state.
- Keeps saturating stall and flush event counters for debug.

Parameters:
CNT_W, 16, width of stall_count and flush_count.
MEM_TIMEOUT, 64, max consecutive MEMWAIT cycles before mem_err; must be >= 1.

Ports:
Clk  input  1  clock, all state updates on posedge.
Clr  input  1  reset, asynchronous, active-high.
id_rs  input  5  rs field of instruction in ID.
id_rt  input  5  rt field of instruction in ID.
id_uses_rt  input  1  ID instruction reads rt as a source.
ex_memread  input  1  instruction in EX is a load.
ex_rd  input  5  destination register of instruction in EX.
ex_branch_taken  input  1  branch/jump resolved taken in EX.
mem_req  input  1  MEM-stage instruction accesses data memory.
mem_ready  input  1  data memory completes access this cycle.
halt  input  1  halt instruction reached MEM.
pc_en  output  1  PC write enable.
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage register enables.
ifid_clr, idex_clr, exmem_clr  output  1 each  active-high flush requests, sampled with the stage enable.
state  output  2  RUN=0, MEMWAIT=1, HALTED=2; 3 unused.
mem_err  output  1  sticky memory timeout flag.
stall_count  output  CNT_W  load-use stall cycles, saturating.
flush_count  output  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Reset value (Clr high, async):
  - state=RUN; mem_err=0; counters=0; wait counter=0.
  - While Clr is high: all enables=0, all clr=1.
- Enable/clr outputs are combinational from state and current inputs. state, counters and mem_err are registered.
- Hazard term: lu = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & (ex_rd==id_rt))).
- RUN, evaluated in this priority order:
  1. mem_req & !mem_ready:
     - All enables=0, all clr=0 (full freeze).
     - Next state=MEMWAIT; wait counter=1.
     - lu and branch are not acted on; they are re-evaluated after the wait.
  2. halt (with the memory access complete or absent):
     - All enables=1 this cycle so the halting instruction retires.
     - Next state=HALTED.
  3. ex_branch_taken:
     - All enables=1; ifid_clr=1, idex_clr=1.
     - flush_count++.
     - Branch overrides a simultaneous lu; the stalled instruction is squashed.
  4. lu:
     - pc_en=0, ifid_en=0; idex_en=1 with idex_clr=1 (bubble); exmem_en=1, memwb_en=1.
     - stall_count++.
     - Exactly 1 cycle per occurrence, because the load advances.
  5. Otherwise: all enables=1, clr=0.
- MEMWAIT:
  - While !mem_ready:
    - All enables=0; wait counter++.
    - When the wait counter reaches MEM_TIMEOUT with mem_ready still low: mem_err<=1, next state=HALTED.
  - On mem_ready:
    - That cycle behaves exactly as RUN rows 2-5.
    - Next state=RUN, or HALTED if halt.
- HALTED:
  - All enables=0, clr=0.
  - Only exit is Clr.
  - Counters and mem_err hold.
- Counters saturate at all-ones; no wrap.
- State encoding 3: behaves as HALTED and sets mem_err.
- Reset asserted mid-MEMWAIT: immediate return to RUN; the wait counter is cleared.
- ex_rd==0 never causes a stall.

Decomposition:
- Shared package: state encoding constants (RUN/MEMWAIT/HALTED) and the REG_ZERO constant.
- One natural sub-module: sat_counter (width-parameterised saturating incrementer with enable and async clear), instantiated twice.
- The wait counter is inline.

Test Plan:
- Load-use: ex_memread=1, ex_rd=8, id_rs=8 for 1 cycle.
  - Response: pc_en=0, ifid_en=0, idex_clr=1, exmem_en=1 that cycle; stall_count 0->1.
  - Same with ex_rd=0: no stall.
- Branch plus load-use together: ex_branch_taken=1 and lu=1.
  - Response: ifid_clr=idex_clr=1, pc_en=1; flush_count=1; stall_count unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1.
  - Response: all enables 0 for 3 cycles with state=MEMWAIT; all enables 1 on the ready cycle; state=RUN next.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready never asserted.
  - Response: mem_err=1 and state=HALTED after the 4th wait cycle; enables stay 0 afterwards.
- Halt: halt=1 in RUN.
  - Response: enables=1 that cycle; then state=HALTED with all enables 0 regardless of inputs.
  - Clr pulse mid-cycle: immediately state=RUN, counters=0.
- Saturation with CNT_W=2: 5 load-use stalls.
  - Response: stall_count stays 3.
